// File: rtl/bram_dp_pkg.sv
// Shared helpers for the dual-port RAM.
// init_word() gives the power-up value of a word. Allocator models can
// reuse it to predict the free-list chain without touching the RTL.
//   i     : word index
//   ofs   : signed link offset (word i points to i+ofs)
//   depth : number of words
//   blank : 1 -> all words are zero, 0 -> circular linked list
package bram_dp_pkg;

  function automatic int init_word(input int i, input int ofs, input int depth,
                                   input bit blank);
    int m;
    if (blank) return 0;
    m = (i + ofs) % depth;
    // SystemVerilog % keeps the sign of the dividend; fold negatives back
    // into range so OFS=-1 wraps word 0 to depth-1.
    if (m < 0) m += depth;
    return m;
  endfunction

endpackage

// File: rtl/bram_dp.sv
// True dual-port synchronous block RAM, single clock, read-first per port.
// Power-up contents come from init_word(): either all zero or a circular
// linked list. This lets a free-list allocator start without an init sweep.
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous active-high; clears doa/dob only
//   ena, wea, addra, dia   port A enable, write enable, address, write data
//   doa                 port A registered read data
//   enb, web, addrb, dib, dob   same for port B
module bram_dp
  import bram_dp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int ADDR  = 4,
  parameter int OFS   = 1,
  parameter int BLANK = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             wea,
  input  logic [ADDR-1:0]  addra,
  input  logic [WIDTH-1:0] dia,
  output logic [WIDTH-1:0] doa,
  input  logic             enb,
  input  logic             web,
  input  logic [ADDR-1:0]  addrb,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] dob
);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t preload();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = WIDTH'(init_word(i, OFS, DEPTH, BLANK != 0));
    end
    return m;
  endfunction

  // The contents are set at configuration time and are never touched by reset.
  mem_t mem = preload();

  logic             a_in_range, b_in_range;
  logic             a_wr, b_wr;
  logic [WIDTH-1:0] a_rd, b_rd;
  logic [WIDTH-1:0] doa_d, dob_d;
  logic [WIDTH-1:0] doa_q = '0;
  logic [WIDTH-1:0] dob_q = '0;

  always_comb begin
    a_in_range = 32'(addra) < DEPTH;
    b_in_range = 32'(addrb) < DEPTH;

    // An out-of-range address reads as zero and never indexes the array.
    a_rd = a_in_range ? mem[addra] : '0;
    b_rd = b_in_range ? mem[addrb] : '0;

    b_wr = enb && web && b_in_range;
    // When both ports write one word on the same edge, port B keeps it.
    // Port A's write is squashed here, so the result does not depend on
    // the order of the two assignments below.
    a_wr = ena && wea && a_in_range && !(b_wr && (addra == addrb));

    doa_d = doa_q;
    if (reset)    doa_d = '0;
    else if (ena) doa_d = a_rd;

    dob_d = dob_q;
    if (reset)    dob_d = '0;
    else if (enb) dob_d = b_rd;
  end

  // Write path. Reads above use the pre-edge contents, so both ports are
  // read-first, for their own writes and for writes from the other port.
  always_ff @(posedge clk) begin
    if (a_wr) mem[addra] <= dia;
    if (b_wr) mem[addrb] <= dib;
  end

  always_ff @(posedge clk) begin
    doa_q <= doa_d;
  end

  always_ff @(posedge clk) begin
    dob_q <= dob_d;
  end

  assign doa = doa_q;
  assign dob = dob_q;

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp. Four instances share all inputs:
//   u16   DEPTH=16 OFS=1
//   u_neg DEPTH=16 OFS=-1
//   u_blk DEPTH=16 BLANK=1
//   u12   DEPTH=12 OFS=1
module tb_bram_dp;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [3:0] addra = '0, addrb = '0, dia = '0, dib = '0;
  logic [3:0] doa16, dob16, doan, dobn, doak, dobk, doa12, dob12;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bram_dp #(.DEPTH(16), .WIDTH(4), .ADDR(4), .OFS(1), .BLANK(0)) u16 (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doa16), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob16));

  bram_dp #(.DEPTH(16), .WIDTH(4), .ADDR(4), .OFS(-1), .BLANK(0)) u_neg (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doan), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dobn));

  bram_dp #(.DEPTH(16), .WIDTH(4), .ADDR(4), .OFS(1), .BLANK(1)) u_blk (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doak), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dobk));

  bram_dp #(.DEPTH(12), .WIDTH(4), .ADDR(4), .OFS(1), .BLANK(0)) u12 (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .doa(doa12), .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob12));

  task automatic check_eq(input string tag, input logic [3:0] got,
                          input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic port_a(input logic en, input logic we, input logic [3:0] a,
                        input logic [3:0] d);
    ena = en; wea = we; addra = a; dia = d;
  endtask

  task automatic port_b(input logic en, input logic we, input logic [3:0] a,
                        input logic [3:0] d);
    enb = en; web = we; addrb = a; dib = d;
  endtask

  // Step one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check_eq("pre_read_doa", doa16, 4'd0);
    check_eq("pre_read_dob", dob16, 4'd0);

    // Preload reads
    port_a(1, 0, 4'd0, 4'd0); port_b(1, 0, 4'd0, 4'd0);
    tick();
    check_eq("pre_ofs1_a0", doa16, 4'd1);
    check_eq("pre_ofsm1_b0", dobn, 4'd15);
    check_eq("pre_blank_a0", doak, 4'd0);
    port_b(0, 0, 4'd0, 4'd0);
    port_a(1, 0, 4'd5, 4'd0);
    tick();
    check_eq("pre_ofs1_a5", doa16, 4'd6);
    port_a(1, 0, 4'd15, 4'd0);
    tick();
    check_eq("pre_ofs1_a15", doa16, 4'd0);
    check_eq("oor_d12_a15", doa12, 4'd0);
    port_a(1, 0, 4'd7, 4'd0);
    tick();
    check_eq("pre_blank_a7", doak, 4'd0);
    check_eq("pre_ofs1_a7", doa16, 4'd8);

    // Read-first on the same port
    port_a(1, 1, 4'd3, 4'd9);
    tick();
    check_eq("rdfirst_old", doa16, 4'd4);
    port_a(1, 0, 4'd3, 4'd0);
    tick();
    check_eq("rdfirst_new", doa16, 4'd9);

    // Both ports write addr 2; port B's data is stored
    port_a(1, 1, 4'd2, 4'd5); port_b(1, 1, 4'd2, 4'd11);
    tick();
    check_eq("coll_b_old", dob16, 4'd3);
    port_a(1, 0, 4'd2, 4'd0); port_b(0, 0, 4'd0, 4'd0);
    tick();
    check_eq("coll_b_wins", doa16, 4'd11);

    // A writes addr 4 while B reads it
    port_a(1, 1, 4'd4, 4'd8); port_b(1, 0, 4'd4, 4'd0);
    tick();
    check_eq("xport_old", dob16, 4'd5);
    port_a(0, 0, 4'd0, 4'd0);
    tick();
    check_eq("xport_new", dob16, 4'd8);
    port_b(0, 0, 4'd0, 4'd0);

    // Enable hold; a write with en=0 must be ignored
    port_a(1, 0, 4'd5, 4'd0);
    tick();
    check_eq("hold_start", doa16, 4'd6);
    port_a(0, 1, 4'd5, 4'd15);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("hold_%0d", i), doa16, 4'd6);
    end

    // Reset clears outputs and overrides reads, but the write still lands
    reset = 1'b1;
    port_a(1, 0, 4'd5, 4'd0); port_b(1, 1, 4'd6, 4'd3);
    tick();
    check_eq("rst_doa", doa16, 4'd0);
    check_eq("rst_dob", dob16, 4'd0);
    reset = 1'b0;
    port_a(1, 0, 4'd3, 4'd0); port_b(1, 0, 4'd6, 4'd0);
    tick();
    check_eq("rst_keep_a3", doa16, 4'd9);
    check_eq("rst_wr_b6", dob16, 4'd3);
    port_a(1, 0, 4'd5, 4'd0); port_b(0, 0, 4'd0, 4'd0);
    tick();
    check_eq("we_no_en_a5", doa16, 4'd6);

    // Out of range on the DEPTH=12 instance
    port_a(1, 1, 4'd13, 4'd7);
    tick();
    port_a(1, 0, 4'd13, 4'd0);
    tick();
    check_eq("oor_d12_rd13", doa12, 4'd0);
    check_eq("inrange_d16_rd13", doa16, 4'd7);
    port_a(1, 0, 4'd0, 4'd0);
    tick();
    check_eq("oor_d12_word0", doa12, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_dp.md
# bram_dp

True dual-port synchronous block RAM of DEPTH words × WIDTH bits, with two independent read/write ports on a single clock. Its power-up contents can be preloaded as a circular linked list, where entry i holds (i+OFS) mod DEPTH. This lets free-list allocators such as memory_allocator use it as their next-pointer store without an initialisation sweep. The block is written to infer a vendor BRAM: registered outputs, no asynchronous read.

## Interface
- DEPTH, 16, number of words
- WIDTH, 4, data width in bits
- ADDR, 4, address width; 2^ADDR ≥ DEPTH
- OFS, 1, signed integer offset for linked-list preload
- BLANK, 0, 1 = preload all words to 0; 0 = linked-list preload
- clk  in  1  clock; all activity on the rising edge
- reset  in  1  synchronous, active-high; clears output registers only
- ena  in  1  port A enable (read and/or write)
- wea  in  1  port A write enable; qualified by ena
- addra  in  ADDR  port A address
- dia  in  WIDTH  port A write data
- doa  out  WIDTH  port A registered read data
- enb, web, addrb, dib, dob  as port A, for port B

## Operation
- Preload at time zero, not on reset:
  - BLANK=1: every word is 0.
  - BLANK=0: word i = ((i+OFS) mod DEPTH) truncated to WIDTH; the modulo is always non-negative, so OFS=-1 makes word 0 hold DEPTH-1.
- Port operation per edge, with en=1:
  - The addressed word is read into the output register, read-first: a write on the same port in the same cycle returns the old contents.
  - If we=1, dia/dib is then stored.
- en=0: no read, no write; the output register holds its value.
- we=1 with en=0 is ignored.
- Cross-port, same address, same edge:
  - Both writing: port B's data is stored.
  - One reads while the other writes: the reader gets the old contents.
- Out-of-range address (≥ DEPTH): a write is dropped; a read loads 0.
- reset=1: doa and dob become 0 on that edge, overriding any read. Writes requested in the same cycle still execute. Memory contents are never cleared by reset.

## Timing
- Read latency is 1 cycle: address and enable sampled at edge N, data valid on doa/dob after edge N, stable until the next enabled read or reset.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1 on either port.
- Outputs before the first read or reset: 0.
- There is no handshake; both ports accept a request every cycle.

## Structure
- Single module, no sub-modules.
- Memory is one unpacked array of WIDTH-bit words, filled by an initial loop.
- Port A and port B each use their own always_ff, both on clk.
- The port-B-wins rule is resolved explicitly so it is not left to simulator ordering.
- A shared package is optional. If used, it holds the pure function init_word(i, OFS, DEPTH, BLANK), returning the preload value so allocator models can reuse it.
- No typedefs are required.

## Test plan
- Preload, DEPTH=16, OFS=1, BLANK=0: read addra=0,5,15 on successive cycles -> doa = 1, 6, 0, each one cycle after its address.
- Preload, OFS=-1: read addrb=0 -> dob=15. Preload, BLANK=1: read addra=7 -> 0.
- Read-first, same port:
  - Cycle 1: ena=1, wea=1, addra=3, dia=9 -> doa = 4 (old value).
  - Cycle 2: read addra=3 -> doa = 9.
- Cross-port collision:
  - Both ports write addr 2 (A dia=5, B dib=11), then port A reads addr 2 -> doa = 11.
  - Port A writes 8 to addr 4 while port B reads addr 4 -> dob = 5 (old value), then 8 on the next read.
- Enable hold and reset:
  - After doa=6, drop ena for 3 cycles -> doa stays 6.
  - Assert reset -> doa = dob = 0 next edge.
  - Read addr 3 after reset -> value written earlier is retained.
- Out of range, DEPTH=12, ADDR=4: write addr 13, then read addr 13 -> 0; word 0 is unchanged.
